accum_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the 16-bit multi-register accumulator datapath.
- Directly upstream of the 16-bit 5-input operand mux: drives its 3-bit select, plus all datapath enables (PC, IR, register file, accumulator, memory).
- Sequences each instruction through fetch/decode/execute/writeback and stalls on a memory-ready handshake.

---
 rtl/accum_ctrl_defs.sv | 48 ++++
 rtl/accum_ctrl_decode.sv | 28 ++
 rtl/accum_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_accum_ctrl_fsm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/accum_ctrl_defs.sv
// Shared encodings for the accumulator control unit: states, opcodes,
// operand-mux sources, ALU operations and the opcode class used by the decoder.
package accum_ctrl_defs;

   localparam logic [2:0] S_FETCH    = 3'd0;
   localparam logic [2:0] S_DECODE   = 3'd1;
   localparam logic [2:0] S_EXEC     = 3'd2;
   localparam logic [2:0] S_MEM_ADDR = 3'd3;
   localparam logic [2:0] S_MEM_WAIT = 3'd4;
   localparam logic [2:0] S_WB       = 3'd5;
   localparam logic [2:0] S_BRANCH   = 3'd6;
   localparam logic [2:0] S_HALT     = 3'd7;

   localparam logic [3:0] OPC_ADD  = 4'd0;
   localparam logic [3:0] OPC_SUB  = 4'd1;
   localparam logic [3:0] OPC_AND  = 4'd2;
   localparam logic [3:0] OPC_OR   = 4'd3;
   localparam logic [3:0] OPC_ADDI = 4'd4;
   localparam logic [3:0] OPC_LW   = 4'd5;
   localparam logic [3:0] OPC_SW   = 4'd6;
   localparam logic [3:0] OPC_BEQZ = 4'd7;
   localparam logic [3:0] OPC_JMP  = 4'd8;
   localparam logic [3:0] OPC_MOVE = 4'd9;
   localparam logic [3:0] OPC_HALT = 4'hF;

   // Operand-mux source codes, shared with the mux instantiation.
   localparam logic [2:0] SEL_ACC      = 3'd0;
   localparam logic [2:0] SEL_REG      = 3'd1;
   localparam logic [2:0] SEL_IMM_SEXT = 3'd2;
   localparam logic [2:0] SEL_CONST_2  = 3'd3;
   localparam logic [2:0] SEL_IMM_SHL1 = 3'd4;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_AND    = 3'd2;
   localparam logic [2:0] ALU_OR     = 3'd3;
   localparam logic [2:0] ALU_PASS_B = 3'd4;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MEM,
      CLS_BRANCH,
      CLS_MOVE,
      CLS_HALT,
      CLS_ILLEGAL
   } opc_class_e;

endpackage

// File: rtl/accum_ctrl_decode.sv
// Combinational opcode classifier feeding the DECODE-state transition.
// The halt opcode is checked first so a remapped HALT_OPC always wins.
module accum_ctrl_decode
   import accum_ctrl_defs::*;
#(
   parameter int                OPC_W    = 4,
   parameter logic [OPC_W-1:0]  HALT_OPC = 4'hF
) (
   input  logic [OPC_W-1:0] opcode_i,
   output opc_class_e       opc_class_o
);

   always_comb begin
      opc_class_o = CLS_ILLEGAL;
      if (opcode_i == HALT_OPC) begin
         opc_class_o = CLS_HALT;
      end else if (opcode_i <= OPC_ADDI) begin
         opc_class_o = CLS_ALU;
      end else if (opcode_i == OPC_LW || opcode_i == OPC_SW) begin
         opc_class_o = CLS_MEM;
      end else if (opcode_i == OPC_BEQZ || opcode_i == OPC_JMP) begin
         opc_class_o = CLS_BRANCH;
      end else if (opcode_i == OPC_MOVE) begin
         opc_class_o = CLS_MOVE;
      end
   end

endmodule

// File: rtl/accum_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback controller for the accumulator datapath.
// ACCUM_ILLEGAL_TRAP_EN: illegal opcodes halt and raise a sticky illegal_trap instead of acting as NOPs.
module accum_ctrl_fsm
   import accum_ctrl_defs::*;
#(
   parameter int                OPC_W    = 4,
   parameter int                SEL_W    = 3,
   parameter logic [OPC_W-1:0]  HALT_OPC = 4'hF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPC_W-1:0] opcode,
   input  logic             acc_zero,
   input  logic             mem_ready,
   output logic [SEL_W-1:0] op_sel,
   output logic [2:0]       alu_op,
   output logic             pc_write,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_addr_sel,
   output logic             reg_write,
   output logic             acc_write,
   output logic             acc_src,
   output logic             halted,
`ifdef ACCUM_ILLEGAL_TRAP_EN
   output logic             illegal_trap,
`endif
   output logic [2:0]       state_dbg
);

   logic [2:0]       state_q, state_d;
   logic [OPC_W-1:0] opc_q, opc_d;
   opc_class_e       dec_cls;
   logic             is_lw;

   accum_ctrl_decode #(
      .OPC_W    (OPC_W),
      .HALT_OPC (HALT_OPC)
   ) u_decode (
      .opcode_i    (opcode),
      .opc_class_o (dec_cls)
   );

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      unique case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            opc_d = opcode;
            case (dec_cls)
               CLS_ALU:    state_d = S_EXEC;
               CLS_MEM:    state_d = S_MEM_ADDR;
               CLS_BRANCH: state_d = S_BRANCH;
               CLS_MOVE:   state_d = S_WB;
               CLS_HALT:   state_d = S_HALT;
`ifdef ACCUM_ILLEGAL_TRAP_EN
               default:    state_d = S_HALT;
`else
               default:    state_d = S_FETCH;
`endif
            endcase
         end
         S_EXEC:     state_d = S_WB;
         S_MEM_ADDR: state_d = S_MEM_WAIT;
         S_MEM_WAIT: if (mem_ready) state_d = S_FETCH;
         S_WB:       state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
      end
   end

`ifdef ACCUM_ILLEGAL_TRAP_EN
   logic trap_q, trap_d;

   assign trap_d = trap_q | (state_q == S_DECODE && dec_cls == CLS_ILLEGAL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) trap_q <= 1'b0;
      else       trap_q <= trap_d;
   end

   assign illegal_trap = trap_q;
`endif

   assign is_lw     = (opc_q == OPC_LW);
   assign state_dbg = state_q;

   // Everything is forced low while reset is held, so an in-flight access drops at once.
   always_comb begin
      op_sel       = SEL_ACC;
      alu_op       = ALU_ADD;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = 1'b0;
      reg_write    = 1'b0;
      acc_write    = 1'b0;
      acc_src      = 1'b0;
      halted       = 1'b0;
      if (!reset) begin
         unique case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               ir_write = mem_ready;
               if (mem_ready) begin
                  op_sel   = SEL_CONST_2;
                  alu_op   = ALU_ADD;
                  pc_write = 1'b1;
               end
            end
            S_DECODE: ;
            S_EXEC: begin
               if (opc_q == OPC_ADDI) begin
                  op_sel = SEL_IMM_SEXT;
                  alu_op = ALU_ADD;
               end else begin
                  op_sel = SEL_REG;
                  alu_op = opc_q[2:0];
               end
            end
            S_MEM_ADDR: begin
               op_sel = SEL_IMM_SEXT;
               alu_op = ALU_ADD;
            end
            S_MEM_WAIT: begin
               mem_addr_sel = 1'b1;
               mem_read     = is_lw;
               mem_write    = !is_lw;
               acc_write    = is_lw && mem_ready;
               acc_src      = is_lw && mem_ready;
            end
            S_WB: begin
               if (opc_q == OPC_MOVE) reg_write = 1'b1;
               else                   acc_write = 1'b1;
            end
            S_BRANCH: begin
               op_sel   = SEL_IMM_SHL1;
               alu_op   = ALU_ADD;
               pc_write = (opc_q == OPC_JMP) || acc_zero;
            end
            S_HALT:     halted = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_accum_ctrl_fsm.sv
// Directed and randomized instruction sequences checked cycle-by-cycle against
// a per-instruction expectation built from the instruction's class.
module tb_accum_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic       acc_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [2:0] op_sel, alu_op, state_dbg;
   logic       pc_write, ir_write, mem_read, mem_write, mem_addr_sel;
   logic       reg_write, acc_write, acc_src, halted;
`ifdef ACCUM_ILLEGAL_TRAP_EN
   logic       illegal_trap;
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   bit trap_exp = 1'b0;

   accum_ctrl_fsm dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .acc_zero     (acc_zero),
      .mem_ready    (mem_ready),
      .op_sel       (op_sel),
      .alu_op       (alu_op),
      .pc_write     (pc_write),
      .ir_write     (ir_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr_sel (mem_addr_sel),
      .reg_write    (reg_write),
      .acc_write    (acc_write),
      .acc_src      (acc_src),
      .halted       (halted),
`ifdef ACCUM_ILLEGAL_TRAP_EN
      .illegal_trap (illegal_trap),
`endif
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic bit rb();
      return bit'($urandom_range(1, 0));
   endfunction

   function automatic logic [18:0] obs_vec();
      logic t;
`ifdef ACCUM_ILLEGAL_TRAP_EN
      t = illegal_trap;
`else
      t = 1'b0;
`endif
      return {state_dbg, op_sel, alu_op, pc_write, ir_write, mem_read, mem_write,
              mem_addr_sel, reg_write, acc_write, acc_src, halted, t};
   endfunction

   // Expected output vector: state, op_sel, alu_op, then the single-bit enables.
   function automatic logic [18:0] ev(input int st, input int sel, input int aop,
                                      input bit pcw, input bit irw, input bit mr,
                                      input bit mw, input bit mas, input bit rw,
                                      input bit aw, input bit as, input bit h);
      logic [2:0] s3, q3, a3;
      s3 = st[2:0];
      q3 = sel[2:0];
      a3 = aop[2:0];
      return {s3, q3, a3, pcw, irw, mr, mw, mas, rw, aw, as, h, trap_exp};
   endfunction

   task automatic check(input string tag, input logic [18:0] e);
      logic [18:0] o;
      o = obs_vec();
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Called at posedge+1: apply mem_ready, check mid-cycle, advance one clock.
   task automatic cyc(input bit mr, input string tag, input logic [18:0] e);
      mem_ready = mr;
      #2;
      check(tag, e);
      @(posedge clk);
      #1;
   endtask

   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      trap_exp = 1'b0;
      check(tag, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("reset_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      reset  = 1'b0;
      opcode = 4'($urandom);
   endtask

   task automatic do_instr(input int opc, input int fw, input int mw,
                           input bit az, input bit abort);
      bit lw, pcw;
      opcode   = 4'($urandom);
      acc_zero = rb();
      for (int i = 0; i < fw; i++)
         cyc(1'b0, "fetch_wait", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      cyc(1'b1, "fetch", ev(0, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      opcode = 4'(opc);
      cyc(rb(), "decode", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      opcode = 4'($urandom);
      if (opc <= 4) begin
         cyc(rb(), "exec", ev(2, (opc < 4) ? 1 : 2, (opc < 4) ? opc : 0,
                              0, 0, 0, 0, 0, 0, 0, 0, 0));
         cyc(rb(), "wb_alu", ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      end else if (opc == 5 || opc == 6) begin
         lw = (opc == 5);
         cyc(rb(), "mem_addr", ev(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         for (int i = 0; i < mw; i++)
            cyc(1'b0, "mem_wait", ev(4, 0, 0, 0, 0, lw, !lw, 1, 0, 0, 0, 0));
         if (abort) begin
            mem_ready = 1'b0;
            async_reset("abort_mem_wait");
         end else begin
            cyc(1'b1, "mem_done", ev(4, 0, 0, 0, 0, lw, !lw, 1, 0, lw, lw, 0));
         end
      end else if (opc == 7 || opc == 8) begin
         acc_zero = az;
         pcw = (opc == 8) || az;
         cyc(rb(), "branch", ev(6, 4, 0, pcw, 0, 0, 0, 0, 0, 0, 0, 0));
      end else if (opc == 9) begin
         cyc(rb(), "wb_move", ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end else if (opc == 15) begin
         for (int i = 0; i < 4; i++)
            cyc(rb(), "halt", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
         async_reset("reset_from_halt");
      end else if (TRAP) begin
         trap_exp = 1'b1;
         for (int i = 0; i < 3; i++)
            cyc(rb(), "illegal_halt", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
         async_reset("reset_from_trap");
      end else begin
         cyc(1'b0, "illegal_nop", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      end
   endtask

   initial begin
      int opc;
      bit ab;
      #12;
      check("reset_state", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1'b0, "first_fetch", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

      do_instr(0, 0, 0, 1'b0, 1'b0);
      do_instr(5, 0, 3, 1'b0, 1'b0);
      do_instr(7, 0, 0, 1'b1, 1'b0);
      do_instr(7, 1, 0, 1'b0, 1'b0);
      do_instr(8, 0, 0, 1'b0, 1'b0);
      do_instr(6, 2, 2, 1'b0, 1'b0);
      do_instr(9, 0, 0, 1'b0, 1'b0);
      do_instr(4, 0, 0, 1'b0, 1'b0);
      do_instr(5, 0, 1, 1'b0, 1'b1);
      do_instr(11, 0, 0, 1'b0, 1'b0);
      do_instr(15, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         opc = int'($urandom_range(15, 0));
         ab  = (opc == 5 || opc == 6) && ($urandom_range(7, 0) == 0);
         do_instr(opc, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), rb(), ab);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
